cout_wb_scheduler: RTL
======================

Name: cout_wb_scheduler

Overview:
- Sequences result writeback from the systolic array's C output through the C-output mapping stage into the TB and CB BRAM banks.
- Accepts one writeback command at a time over a valid/ready handshake.
- Per valid C row, drives the 3-bit mapping mode; one cycle later, drives the per-bank write enables and port-B row address so they align with the mapping stage's registered dinb outputs.
- Pulses done when the last row has been written.

Parameters:
- X, 4, systolic array row-output lanes (X <= L)
- L, 4, number of BRAM banks per buffer
- AW, 10, BRAM row address width
- LEN_W, 8, row-count width

Ports:
- clk  in  1  clock
- sys_rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  scheduler can accept a command
- cmd_type  in  2  00=TB, 01=CB, 10=NEW (landmark init), 11=reserved (treated as CB)
- cmd_neg  in  1  reverse lane order (TB/CB only)
- cmd_len  in  LEN_W  number of C rows to write
- cmd_addr  in  AW  first BRAM row address
- cmd_lnum  in  2  landmark number low bits, already incremented (NEW only)
- c_valid  in  1  C_data row valid this cycle
- C_map_mode  out  3  mapping mode to the C-output mapping stage
- TB_web  out  L  TB per-bank write enable
- CB_web  out  L  CB per-bank write enable
- TB_addrb  out  AW  TB port-B address
- CB_addrb  out  AW  CB port-B address
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, active-high):
  - state=IDLE; all counters, TB_web, CB_web, TB_addrb, CB_addrb, C_map_mode, done and busy are 0.
  - Reset mid-command aborts it immediately; no further writes; no done pulse.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch the mode, cmd_len, cmd_addr and the web pattern; row counter r=0.
  - cmd_len=0: go to DONE (no writes). Otherwise go to RUN.
  - c_valid is ignored in IDLE.
- Mode latch, held registered for the whole command until the next accept:
  - TB: {2'b00, cmd_neg} (000 or 001).
  - CB: {2'b01, cmd_neg} (010 or 011).
  - NEW: {1'b1, cmd_lnum} (11 -> 111, 00 -> 100, 01 -> 101, 10 -> 110).
- Web pattern:
  - TB/CB: lanes 0..X-1 set.
  - NEW with lnum 11 or 10: 4'b0011.
  - NEW with lnum 00 or 01: 4'b1100.
- RUN:
  - Each cycle with c_valid=1 (cycle k):
    - Next cycle: the target web (TB_web for TB, CB_web otherwise) = pattern, target addrb = latched addr + r; the other buffer's web=0.
    - r increments.
  - c_valid=0 cycles: web=0 next cycle; addrb holds.
  - When c_valid arrives with r = len-1: go to DRAIN.
- DRAIN: the last write is on the bus this cycle (web set by the previous c_valid). Go to DONE. c_valid here is ignored.
- DONE: done=1 for exactly one cycle; web=0; go to IDLE.
- cmd_ready=1 only in IDLE; busy=1 in RUN, DRAIN and DONE.
- Address arithmetic: addr + r is computed modulo 2^AW; wrap-around is permitted and not flagged.
- Latency: write enable and address trail c_valid by exactly 1 cycle, matching the mapping stage's registered output.
- Extra c_valid pulses beyond cmd_len are never written.

Test Plan:
- TB, neg=0, len=3, addr=10, c_valid high 3 cycles -> C_map_mode=000; TB_web=1111 in cycles k+1..k+3 with TB_addrb 10, 11, 12; CB_web=0 throughout; done one cycle after last write.
- CB, neg=1, len=2, addr=5, c_valid pattern 1,0,0,1 -> C_map_mode=011; CB_web=1111 at addr 5, then idle for 2 cycles, then addr 6; done follows.
- NEW with lnum=01, len=1, addr=7 -> C_map_mode=101; CB_web=1100 at addr 7. Repeat with lnum=10 -> mode 110, CB_web=0011.
- len=0 -> cmd_ready drops; done pulses the cycle after accept; no web asserted.
- sys_rst asserted after 1 of 4 rows -> all outputs 0 immediately; later rows produce no writes; no done pulse; a subsequent command proceeds normally.
- cmd_valid held during RUN with addr=1023, len=2 -> second command not accepted until IDLE; addresses 1023 then 0 (wrap).

Source files
------------

// File: rtl/cout_wb_scheduler.sv
// Writeback scheduler: steps C rows through the output mapping stage into the TB/CB BRAM banks.
// Write enables and port-B addresses are registered, so they trail c_valid by one cycle.
module cout_wb_scheduler #(
    parameter int X     = 4,
    parameter int L     = 4,
    parameter int AW    = 10,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             sys_rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_type,
    input  logic             cmd_neg,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [AW-1:0]    cmd_addr,
    input  logic [1:0]       cmd_lnum,
    input  logic             c_valid,
    output logic [2:0]       C_map_mode,
    output logic [L-1:0]     TB_web,
    output logic [L-1:0]     CB_web,
    output logic [AW-1:0]    TB_addrb,
    output logic [AW-1:0]    CB_addrb,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [L-1:0] LANE_MASK = {L{1'b1}} >> (L - X);
    localparam logic [L-1:0] LO_HALF   = {L{1'b1}} >> (L - L/2);
    localparam logic [L-1:0] HI_HALF   = ~LO_HALF;

    state_t           state, state_nx;
    logic [2:0]       mode, mode_in;
    logic [L-1:0]     pat, pat_in;
    logic             to_tb, tb_in;
    logic [AW-1:0]    base, addr_nx;
    logic [LEN_W-1:0] len, r;
    logic             accept, wr, last;

    assign accept  = (state == IDLE) && cmd_valid;
    assign wr      = (state == RUN) && c_valid;
    assign last    = wr && (r == len - 1'b1);
    assign addr_nx = base + AW'(r);

    assign cmd_ready  = (state == IDLE);
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign C_map_mode = mode;

    // Reserved type 11 falls through to the CB default.
    always_comb begin
        mode_in = {2'b01, cmd_neg};
        pat_in  = LANE_MASK;
        tb_in   = 1'b0;
        case (cmd_type)
            2'b00: begin
                mode_in = {2'b00, cmd_neg};
                tb_in   = 1'b1;
            end
            2'b10: begin
                mode_in = {1'b1, cmd_lnum};
                pat_in  = cmd_lnum[1] ? LO_HALF : HI_HALF;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (cmd_valid) state_nx = (cmd_len == '0) ? DONE : RUN;
            RUN:     if (last) state_nx = DRAIN;
            DRAIN:   state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) state <= IDLE;
        else         state <= state_nx;
    end

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            mode     <= '0;
            pat      <= '0;
            to_tb    <= 1'b0;
            base     <= '0;
            len      <= '0;
            r        <= '0;
            TB_web   <= '0;
            CB_web   <= '0;
            TB_addrb <= '0;
            CB_addrb <= '0;
        end else begin
            TB_web <= '0;
            CB_web <= '0;
            if (accept) begin
                mode  <= mode_in;
                pat   <= pat_in;
                to_tb <= tb_in;
                base  <= cmd_addr;
                len   <= cmd_len;
                r     <= '0;
            end
            if (wr) begin
                if (to_tb) begin
                    TB_web   <= pat;
                    TB_addrb <= addr_nx;
                end else begin
                    CB_web   <= pat;
                    CB_addrb <= addr_nx;
                end
                r <= r + 1'b1;
            end
        end
    end
endmodule
